// File: rtl/sr_latch_driver.sv
// Writer-side sequencer for a cross-coupled NAND SR latch: guarded, single-line
// active-low pulses on s_n/r_n, followed by a q/qbar readback check.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s_n,
    output logic r_n,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic done,
    output logic err,
    output logic busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] IDLE   = 3'd0;
    localparam logic [ST_W-1:0] GUARD  = 3'd1;
    localparam logic [ST_W-1:0] PULSE  = 3'd2;
    localparam logic [ST_W-1:0] SETTLE = 3'd3;
    localparam logic [ST_W-1:0] CHECK  = 3'd4;

    // Timing parameters must fit the 4-bit down-counter and be non-zero.
    if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
        $error("PULSE_W out of range 1..15");
    end
    if (GAP_W < 1 || GAP_W > 15) begin : g_bad_gap_w
        $error("GAP_W out of range 1..15");
    end

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_q;
    logic             dir_d;
    logic             s_n_d;
    logic             r_n_d;
    logic             ready_d;
    logic             done_d;
    logic             err_d;
    logic             mismatch_c;

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        err_d      = err;
        mismatch_c = (q_fb != dir_q) || (qbar_fb == q_fb);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = GUARD;
                    cnt_d   = CNT_W'(GAP_W - 1);
                    dir_d   = req_set;
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(GAP_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = mismatch_c;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Only one line can ever be low: the pulse selects exactly one by dir.
        s_n_d   = !((state_d == PULSE) && dir_d);
        r_n_d   = !((state_d == PULSE) && !dir_d);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            s_n       <= 1'b1;
            r_n       <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            s_n       <= s_n_d;
            r_n       <= r_n_d;
            req_ready <= ready_d;
            busy      <= !ready_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default-timing instance for per-cycle
// waveform checks, plus a PULSE_W=3/GAP_W=2 instance for back-to-back traffic.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst;

    logic req_valid, req_set, req_ready, s_n, r_n, q_fb, qbar_fb, done, err, busy;
    logic req_valid_b, req_set_b, req_ready_b, s_n_b, r_n_b, q_fb_b, qbar_fb_b;
    logic done_b, err_b, busy_b;

    logic lat_q   = 1'b0;
    logic lat_q_b = 1'b0;
    int   mode;   // 0 = healthy latch, 1 = q stuck at 0, 2 = q=qbar=1

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic set;
        int   mode;
        logic exp_err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set),
        .req_ready(req_ready), .s_n(s_n), .r_n(r_n), .q_fb(q_fb),
        .qbar_fb(qbar_fb), .done(done), .err(err), .busy(busy)
    );

    sr_latch_driver #(.PULSE_W(3), .GAP_W(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_set(req_set_b),
        .req_ready(req_ready_b), .s_n(s_n_b), .r_n(r_n_b), .q_fb(q_fb_b),
        .qbar_fb(qbar_fb_b), .done(done_b), .err(err_b), .busy(busy_b)
    );

    // NAND latch models; a low drive line forces the latch state.
    always_ff @(posedge clk) begin
        if (!s_n) lat_q <= 1'b1;
        else if (!r_n) lat_q <= 1'b0;
        if (!s_n_b) lat_q_b <= 1'b1;
        else if (!r_n_b) lat_q_b <= 1'b0;
    end

    assign q_fb      = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : lat_q;
    assign qbar_fb   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : ~lat_q;
    assign q_fb_b    = lat_q_b;
    assign qbar_fb_b = ~lat_q_b;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One request on the default instance; called at a negedge with the DUT idle.
    task automatic do_req(input logic set, input int m, input logic exp_err, input string tag);
        logic pulse;
        chk({tag, " ready_at_start"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_set   = set;
        mode      = m;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_set   = ~set;
            end
            pulse = (c == 2) || (c == 3);
            chk($sformatf("%s c%0d s_n", tag, c), s_n, !(pulse && set));
            chk($sformatf("%s c%0d r_n", tag, c), r_n, !(pulse && !set));
            chk($sformatf("%s c%0d ready", tag, c), req_ready, c >= 6);
            chk($sformatf("%s c%0d busy", tag, c), busy, c < 6);
            chk($sformatf("%s c%0d done", tag, c), done, c == 6);
            if (c == 6) chk($sformatf("%s err", tag), err, exp_err);
        end
        mode = 0;
    endtask

    initial begin
        int   cyc;
        int   prev;
        int   waited;
        logic dir_b_exp;

        vecs[0] = '{set: 1'b1, mode: 0, exp_err: 1'b0};
        vecs[1] = '{set: 1'b0, mode: 0, exp_err: 1'b0};
        vecs[2] = '{set: 1'b1, mode: 1, exp_err: 1'b1};
        vecs[3] = '{set: 1'b0, mode: 0, exp_err: 1'b0};
        vecs[4] = '{set: 1'b1, mode: 0, exp_err: 1'b0};
        vecs[5] = '{set: 1'b1, mode: 0, exp_err: 1'b0};
        vecs[6] = '{set: 1'b1, mode: 2, exp_err: 1'b1};
        vecs[7] = '{set: 1'b0, mode: 2, exp_err: 1'b1};

        rst = 1'b1;
        req_valid = 1'b0;
        req_set = 1'b0;
        req_valid_b = 1'b0;
        req_set_b = 1'b0;
        mode = 0;
        @(negedge clk);
        chk("rst s_n", s_n, 1'b1);
        chk("rst r_n", r_n, 1'b1);
        chk("rst ready", req_ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            do_req(vecs[i].set, vecs[i].mode, vecs[i].exp_err, $sformatf("vec%0d", i));

        // Async reset in the middle of a set pulse; err is 1 from the last vector.
        req_valid = 1'b1;
        req_set   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort pre s_n", s_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("abort s_n", s_n, 1'b1);
        chk("abort r_n", r_n, 1'b1);
        chk("abort ready", req_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort err", err, 1'b0);
        chk("abort done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("abort idle c%0d done", c), done, 1'b0);
            chk($sformatf("abort idle c%0d ready", c), req_ready, 1'b1);
        end
        do_req(1'b0, 0, 1'b0, "post_abort_clr");
        do_req(1'b1, 0, 1'b0, "post_abort_set");

        // Back-to-back traffic on the wider-timing instance.
        cyc  = 0;
        prev = 0;
        dir_b_exp = 1'b0;
        req_set_b   = 1'($urandom_range(1, 0));
        req_valid_b = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            waited = 0;
            while (!req_ready_b && waited < 20) begin
                @(negedge clk);
                cyc++;
                waited++;
                chk("b overlap", s_n_b | r_n_b, 1'b1);
            end
            if (!req_ready_b) begin
                chk("b ready timeout", 1'b0, 1'b1);
                break;
            end
            if (n > 0) begin
                chk_int($sformatf("b%0d interval", n), cyc - prev, 9);
                chk($sformatf("b%0d done", n), done_b, 1'b1);
                chk($sformatf("b%0d err", n), err_b, 1'b0);
                chk($sformatf("b%0d latch", n), lat_q_b, dir_b_exp);
            end
            prev = cyc;
            dir_b_exp = req_set_b;
            @(negedge clk);
            cyc++;
            chk("b overlap", s_n_b | r_n_b, 1'b1);
            req_set_b = 1'($urandom_range(1, 0));
        end
        req_valid_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
